// File: rtl/riscv_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// riscv_mem_arbiter_if
//
// Bundles every bus signal around the single-port memory arbiter: the three
// requester ports (program loader, core load/store, core fetch), the shared
// read-data return, the registered memory command and the core stall flag.
//
// Parameters:
//   ADDR_W - memory word-address width
//   DATA_W - data width
//
// Modports:
//   slave  - the arbiter: samples requests and memory read data, drives
//            grants, rvalids, rdata, the memory command and core_stall
//   master - the surrounding system (requesters + memory), mirror image
// -----------------------------------------------------------------------------
interface riscv_mem_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) ();
    // Program loader
    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_gnt;
    logic              ld_rvalid;

    // Core load/store
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;

    // Core instruction fetch (read only)
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;

    // Shared read data, qualified by the *_rvalid strobes
    logic [DATA_W-1:0] rdata;

    // Memory command and read data
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // High while the loader owns the memory
    logic              core_stall;

    modport slave (
        input  ld_req, ld_we, ld_addr, ld_wdata,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  if_req, if_addr,
        input  mem_rdata,
        output ld_gnt, ld_rvalid,
        output dm_gnt, dm_rvalid,
        output if_gnt, if_rvalid,
        output rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output core_stall
    );

    modport master (
        output ld_req, ld_we, ld_addr, ld_wdata,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output if_req, if_addr,
        output mem_rdata,
        input  ld_gnt, ld_rvalid,
        input  dm_gnt, dm_rvalid,
        input  if_gnt, if_rvalid,
        input  rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  core_stall
    );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// riscv_mem_arbiter
//
// Shares one synchronous memory port between the external program loader,
// core load/store and core instruction fetch. Grants are combinational, at
// most one per cycle, with fixed priority loader > load/store > fetch. A
// loader request moves the arbiter into LOAD, where the core is stalled and
// only the loader may be granted until ld_req drops.
//
// The granted request is registered into the memory command (mem_*) at the
// grant edge. Reads carry a 2-bit owner tag through two register stages so
// that the owner's rvalid pulses in the cycle mem_rdata is valid
// (grant N, mem_en N+1, rvalid N+2). Writes carry no tag.
//
// Optional feature (macro RISCV_ARB_STARVE_GUARD_EN):
//   When defined, a counter tracks consecutive cycles in RUN in which fetch
//   asked but was not granted. Once it reaches STARVE_MAX, fetch is promoted
//   above load/store (never above the loader). When undefined, priority is
//   strictly fixed and STARVE_MAX has no effect.
//
// Parameters:
//   ADDR_W     - memory word-address width
//   DATA_W     - data width
//   STARVE_MAX - fetch starvation limit in denied cycles (>= 1)
//
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous, active-low reset
//   bus   - riscv_mem_arbiter_if.slave: requester, memory and stall signals
// -----------------------------------------------------------------------------
module riscv_mem_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    riscv_mem_arbiter_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

    // Owner of an outstanding read; OWN_NONE marks an idle slot or a write
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_LD   = 2'd1,
        OWN_DM   = 2'd2,
        OWN_IF   = 2'd3
    } owner_e;

    state_e             state_q;
    state_e             state_d;

    logic               ld_gnt;
    logic               dm_gnt;
    logic               if_gnt;
    logic               any_gnt;
    logic               starve_hit;

    logic               mem_en_q;
    logic               mem_we_q;
    logic               mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q;
    logic [DATA_W-1:0]  mem_wdata_d;

    owner_e             tag_iss_q;   // owner of the read on the memory port now
    owner_e             tag_iss_d;
    owner_e             tag_ret_q;   // owner of the data on mem_rdata now

    // -------------------------------------------------------------------------
    // Grant selection and state transition
    // -------------------------------------------------------------------------
    always_comb begin
        ld_gnt  = 1'b0;
        dm_gnt  = 1'b0;
        if_gnt  = 1'b0;
        state_d = state_q;

        // Grants are combinational from the requests, so they are gated
        // off while reset is asserted to keep every output at 0.
        if (reset) begin
            unique case (state_q)
                ST_RUN: begin
                    if (bus.ld_req) begin
                        ld_gnt  = 1'b1;
                        state_d = ST_LOAD;
                    end else if (bus.if_req && starve_hit) begin
                        if_gnt = 1'b1;
                    end else if (bus.dm_req) begin
                        dm_gnt = 1'b1;
                    end else if (bus.if_req) begin
                        if_gnt = 1'b1;
                    end
                end
                ST_LOAD: begin
                    ld_gnt = bus.ld_req;
                    if (!bus.ld_req) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    assign any_gnt = ld_gnt | dm_gnt | if_gnt;

    // -------------------------------------------------------------------------
    // Fetch starvation guard
    // -------------------------------------------------------------------------
`ifdef RISCV_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;

    assign starve_hit = (starve_cnt_q == STARVE_LIM);

    // Counts only while fetch is denied in RUN. It saturates at the limit:
    // the only way to be denied at the limit is a loader request, which
    // moves to LOAD and clears the count on the following cycle anyway.
    always_comb begin
        starve_cnt_d = '0;
        if (state_q == ST_RUN && bus.if_req && !if_gnt) begin
            starve_cnt_d = starve_hit ? starve_cnt_q : starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    // Strict fixed priority: fetch is never promoted. STARVE_MAX is only
    // referenced so the parameter stays part of the interface in this build.
    assign starve_hit = 1'b0 & (STARVE_MAX >= 1);
`endif

    // -------------------------------------------------------------------------
    // Command mux: capture the granted requester's command
    // -------------------------------------------------------------------------
    always_comb begin
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;    // address/data hold when idle
        mem_wdata_d = mem_wdata_q;
        tag_iss_d   = OWN_NONE;

        if (ld_gnt) begin
            mem_we_d    = bus.ld_we;
            mem_addr_d  = bus.ld_addr;
            mem_wdata_d = bus.ld_wdata;
            tag_iss_d   = bus.ld_we ? OWN_NONE : OWN_LD;
        end else if (dm_gnt) begin
            mem_we_d    = bus.dm_we;
            mem_addr_d  = bus.dm_addr;
            mem_wdata_d = bus.dm_wdata;
            tag_iss_d   = bus.dm_we ? OWN_NONE : OWN_DM;
        end else if (if_gnt) begin
            mem_addr_d  = bus.if_addr;
            tag_iss_d   = OWN_IF;
        end
    end

    // -------------------------------------------------------------------------
    // State, command and read-return registers
    // -------------------------------------------------------------------------
    // Reset also discards both tag stages, so reads issued before reset
    // never produce an rvalid afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tag_iss_q   <= OWN_NONE;
            tag_ret_q   <= OWN_NONE;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= any_gnt;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tag_iss_q   <= tag_iss_d;
            tag_ret_q   <= tag_iss_q;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.ld_gnt     = ld_gnt;
    assign bus.dm_gnt     = dm_gnt;
    assign bus.if_gnt     = if_gnt;

    assign bus.ld_rvalid  = (tag_ret_q == OWN_LD);
    assign bus.dm_rvalid  = (tag_ret_q == OWN_DM);
    assign bus.if_rvalid  = (tag_ret_q == OWN_IF);
    assign bus.rdata      = bus.mem_rdata;

    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

    assign bus.core_stall = (state_q == ST_LOAD);

endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Single-port memory arbiter placed between the RISC-V core and its unified instruction/data memory inside `top_riscv`. It shares one synchronous memory port among three requesters: the external program loader, core load/store, and core instruction fetch. It also sequences a loader mode that stalls the core while a program is written.

## Interface
- `ADDR_W`, default 5: memory word-address width.
- `DATA_W`, default 32: data width.
- `STARVE_MAX`, default 4: fetch starvation limit, in consecutive denied cycles. Must be ≥ 1.

Ports:
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `ld_req`, `ld_we`  in  1: loader request and write enable.
- `ld_addr`  in  ADDR_W; `ld_wdata`  in  DATA_W: loader address and write data.
- `ld_gnt`, `ld_rvalid`  out  1: loader grant and read-data valid.
- `dm_req`, `dm_we`  in  1; `dm_addr`  in  ADDR_W; `dm_wdata`  in  DATA_W: load/store request.
- `dm_gnt`, `dm_rvalid`  out  1: load/store grant and read-data valid.
- `if_req`  in  1; `if_addr`  in  ADDR_W: fetch request.
- `if_gnt`, `if_rvalid`  out  1: fetch grant and read-data valid.
- `rdata`  out  DATA_W: shared read data, equal to `mem_rdata`. Qualified by the `*_rvalid` signals.
- `mem_en`, `mem_we`  out  1; `mem_addr`  out  ADDR_W; `mem_wdata`  out  DATA_W: registered memory command.
- `mem_rdata`  in  DATA_W: memory read data, valid 1 cycle after `mem_en`.
- `core_stall`  out  1: high while in LOAD state.

## Operation
- **States:** RUN and LOAD. Reset state is RUN.
- **RUN:**
  - Grants are combinational, one per cycle, to the highest-priority requester: loader > load/store > fetch.
  - If `ld_req` is high: the loader is granted that cycle and the state moves to LOAD at the next edge.
- **LOAD:**
  - Only the loader can be granted. `dm_gnt` and `if_gnt` are held at 0, and `core_stall` is 1.
  - The state returns to RUN at the first edge where `ld_req` is 0.
- **Handshake:**
  - A requester holds `req`, `addr`, `we` and `wdata` stable until it samples its `gnt` high.
  - The transfer completes at that edge. The requester may present its next request in the following cycle.
- **Issue:**
  - At the grant edge, `mem_en`=1 and `mem_we`/`mem_addr`/`mem_wdata` are registered from the granted requester.
  - If there is no grant, `mem_en`=0 and `mem_we`=0.
- **Read return:**
  - A 2-bit owner tag is registered alongside each non-write issue.
  - One cycle later, exactly one of `ld_rvalid`, `dm_rvalid` or `if_rvalid` pulses for 1 cycle.
  - Writes produce no `rvalid`.
- **Starvation guard:**
  - Counter width is clog2(STARVE_MAX+1).
  - It increments in RUN each cycle that `if_req`=1 and `if_gnt`=0.
  - It clears when fetch is granted, when `if_req`=0, or in LOAD.
  - While the counter equals STARVE_MAX, fetch beats load/store. It never beats the loader.
- **Boundary cases:**
  - All requests simultaneous in RUN: loader wins.
  - Reads already in flight when entering LOAD still return their `rvalid` to the original owner.
  - Address wrap-around is the requester's concern; addresses pass through unmodified.

## Timing
- **Reset values:** all `*_gnt`, `*_rvalid`, `mem_en`, `mem_we` and `core_stall` are 0; `mem_addr` and `mem_wdata` are 0; the counter is 0; the state is RUN.
- **Asynchronous reset mid-operation:** in-flight tags are discarded. No `rvalid` follows for reads issued before reset.
- **Latency, cycle N = grant cycle:**
  - N+1: `mem_en` high.
  - N+2: `*_rvalid` high with `rdata` valid.
- **Throughput:** one access per cycle with back-to-back grants.
- **LOAD exit:** if `ld_req` drops in cycle M, the state is RUN from M+1 and core grants are possible in M+1.

## Configuration
- `RISCV_ARB_STARVE_GUARD_EN` defined: the starvation counter and fetch promotion are present, as described above.
- Not defined: no counter, and strict fixed priority (loader > load/store > fetch). A continuous `dm_req` starves fetch indefinitely. `STARVE_MAX` is ignored.

## Test plan
- **Reset:**
  - Stimulus: drive `reset`=0 with random requests.
  - Required: all outputs 0. After release, state is RUN and `core_stall`=0.
- **Fetch alone:**
  - Stimulus: `if_req`=1, `if_addr`=5, memory word 5 = 0x00500093.
  - Required: `if_gnt` the same cycle; `mem_en`=1 with `mem_addr`=5 the next cycle; `if_rvalid`=1 with `rdata`=0x00500093 two cycles after the grant.
- **Contention with guard, STARVE_MAX=4:**
  - Stimulus: `dm_req` and `if_req` held high for 6 cycles.
  - Required with `RISCV_ARB_STARVE_GUARD_EN` defined: `dm_gnt` in cycles 1–4, `if_gnt` in cycle 5, `dm_gnt` in cycle 6.
  - Required without the macro: `dm_gnt` in all 6 cycles.
- **Loader mode:**
  - Stimulus: loader writes 0x00000013 to addresses 0–3 with `ld_we`=1 while `if_req`=1.
  - Required: `core_stall`=1 from the second cycle; `if_gnt`=0 throughout; four `mem_we` pulses; `ld_rvalid` never asserted.
  - After `ld_req` drops: RUN next cycle and `if_gnt`=1 in that cycle.
- **Store:**
  - Stimulus: `dm_we`=1, `dm_addr`=7, `dm_wdata`=0xDEADBEEF.
  - Required: `mem_we`=1 with `mem_addr`=7 and `mem_wdata`=0xDEADBEEF one cycle after the grant; no `dm_rvalid`; a later fetch of address 7 returns 0xDEADBEEF.
- **Reset mid-read:**
  - Stimulus: assert `reset`=0 in the cycle after a `dm` read grant.
  - Required: `dm_rvalid` stays 0; outputs return to their reset values immediately.
